register_file_mp: RTL and testbench

Parametrised multi-port integer register file with an integrated pending-write scoreboard, the successor to the two-read/one-write core register file. It serves the decode stage of the pipelined core: N read ports feed operand fetch, M write-back ports retire results, and per-register pending bits tell hazard logic whether an operand's producer is still in flight. Register 0 is hardwired to zero; same-cycle write-to-read bypass is optional.

---
 rtl/register_file_mp_pkg.sv | 12 +
 rtl/register_file_mp_reg_scoreboard.sv | 54 +++++
 rtl/register_file_mp.sv | 105 ++++++++++
 tb/tb_register_file_mp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// Shared core definitions for the multi-port register file: data width,
// register-address width and the word/address typedefs used across the core.
package register_file_mp_pkg;

    localparam int CORE_XLEN        = 32;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int REG_AW           = $clog2(DEFAULT_NUM_REGS);

    typedef logic [CORE_XLEN-1:0] word_t;
    typedef logic [REG_AW-1:0]    reg_addr_t;

endpackage : register_file_mp_pkg

// File: rtl/register_file_mp_reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared by any enabled write-back port; x0 is never pending.
module reg_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int NUM_WRITE = 2,
    parameter int AW        = $clog2(NUM_REGS)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   issue_valid_i,
    input  logic [AW-1:0]          issue_register_i,
    input  logic [NUM_WRITE-1:0]   clear_valid_i,
    input  logic [NUM_WRITE*AW-1:0] clear_register_i,
    output logic [NUM_REGS-1:0]    pending_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [AW-1:0]       clearAddr [NUM_WRITE];

    always_comb begin
        for (int k = 0; k < NUM_WRITE; k++) begin
            clearAddr[k] = clear_register_i[k*AW +: AW];
        end
    end

    // Clears are applied before the issue set so a same-cycle issue keeps the
    // register pending: the newly issued producer is still outstanding.
    always_comb begin
        pending_d = pending_q;
        for (int k = 0; k < NUM_WRITE; k++) begin
            if (clear_valid_i[k]) begin
                pending_d[clearAddr[k]] = 1'b0;
            end
        end
        if (issue_valid_i) begin
            pending_d[issue_register_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule : reg_scoreboard

// File: rtl/register_file_mp.sv
// Multi-port integer register file with pending-write scoreboard for decode.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to reads.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int   XLEN      = CORE_XLEN,
    parameter int   NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int   NUM_READ  = 2,
    parameter int   NUM_WRITE = 2,
    localparam int  AW        = $clog2(NUM_REGS)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_READ*AW-1:0]    read_register_i,
    output logic [NUM_READ*XLEN-1:0]  register_data_o,
    output logic [NUM_READ-1:0]       pending_o,
    input  logic [NUM_WRITE*AW-1:0]   write_register_i,
    input  logic [NUM_WRITE*XLEN-1:0] write_back_data_i,
    input  logic [NUM_WRITE-1:0]      ctrl_write_back_i,
    input  logic                      issue_valid_i,
    input  logic [AW-1:0]             issue_register_i
);

    // x0 has no storage; the array starts at x1.
    logic [XLEN-1:0]     regFile_q [1:NUM_REGS-1];
    logic [XLEN-1:0]     regFile_d [1:NUM_REGS-1];

    logic [AW-1:0]       wrAddr    [NUM_WRITE];
    logic [XLEN-1:0]     wrData    [NUM_WRITE];
    logic [NUM_WRITE-1:0] wrHit;
    logic [AW-1:0]       rdAddr    [NUM_READ];
    logic [NUM_REGS-1:0] pendingVec;

    always_comb begin
        for (int k = 0; k < NUM_WRITE; k++) begin
            wrAddr[k] = write_register_i[k*AW +: AW];
            wrData[k] = write_back_data_i[k*XLEN +: XLEN];
            wrHit[k]  = ctrl_write_back_i[k] && (wrAddr[k] != '0);
        end
        for (int i = 0; i < NUM_READ; i++) begin
            rdAddr[i] = read_register_i[i*AW +: AW];
        end
    end

    // Ports are applied in ascending order so the highest index wins a collision.
    always_comb begin
        regFile_d = regFile_q;
        for (int k = 0; k < NUM_WRITE; k++) begin
            if (wrHit[k]) begin
                regFile_d[wrAddr[k]] = wrData[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regFile_q[r] <= '0;
            end
        end else begin
            regFile_q <= regFile_d;
        end
    end

    reg_scoreboard #(
        .NUM_REGS  (NUM_REGS),
        .NUM_WRITE (NUM_WRITE),
        .AW        (AW)
    ) u_scoreboard (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .issue_valid_i    (issue_valid_i),
        .issue_register_i (issue_register_i),
        .clear_valid_i    (wrHit),
        .clear_register_i (write_register_i),
        .pending_o        (pendingVec)
    );

    // Forwarding is suppressed during reset so reads show the stored state only.
    always_comb begin
        register_data_o = '0;
        pending_o       = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (rdAddr[i] != '0) begin
                register_data_o[i*XLEN +: XLEN] = regFile_q[rdAddr[i]];
                pending_o[i]                    = pendingVec[rdAddr[i]];
            end
`ifdef REGFILE_BYPASS_EN
            if (reset_i) begin
                for (int k = 0; k < NUM_WRITE; k++) begin
                    if (wrHit[k] && (wrAddr[k] == rdAddr[i])) begin
                        register_data_o[i*XLEN +: XLEN] = wrData[k];
                        pending_o[i]                    = 1'b0;
                    end
                end
            end
`else
            if (rdAddr[i] == '0) begin
                pending_o[i] = 1'b0;
            end
`endif
        end
    end

endmodule : register_file_mp

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp: stimulus pushes predicted read results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_register_file_mp;
    import register_file_mp_pkg::*;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int NUM_READ  = 2;
    localparam int NUM_WRITE = 2;
    localparam int AW        = 5;

    logic                      clk = 1'b0;
    logic                      reset_i;
    logic [NUM_READ*AW-1:0]    read_register_i;
    logic [NUM_READ*XLEN-1:0]  register_data_o;
    logic [NUM_READ-1:0]       pending_o;
    logic [NUM_WRITE*AW-1:0]   write_register_i;
    logic [NUM_WRITE*XLEN-1:0] write_back_data_i;
    logic [NUM_WRITE-1:0]      ctrl_write_back_i;
    logic                      issue_valid_i;
    logic [AW-1:0]             issue_register_i;

    always #5 clk = ~clk;

    register_file_mp #(
        .XLEN      (XLEN),
        .NUM_REGS  (NUM_REGS),
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .read_register_i   (read_register_i),
        .register_data_o   (register_data_o),
        .pending_o         (pending_o),
        .write_register_i  (write_register_i),
        .write_back_data_i (write_back_data_i),
        .ctrl_write_back_i (ctrl_write_back_i),
        .issue_valid_i     (issue_valid_i),
        .issue_register_i  (issue_register_i)
    );

    typedef struct packed {
        logic [NUM_READ*XLEN-1:0] data;
        logic [NUM_READ-1:0]      pend;
    } expect_t;

    word_t   modelMem  [NUM_REGS];
    bit      modelPend [NUM_REGS];
    expect_t expQ [$];
    int      testsRun    = 0;
    int      testsFailed = 0;
    int      cycleNum    = 0;

    // Architectural view: each read returns the latest retired value, or the
    // highest-numbered same-cycle writer when forwarding is built in.
    function automatic expect_t predict(logic [NUM_READ*AW-1:0] ra,
                                        logic [NUM_WRITE*AW-1:0] wa,
                                        logic [NUM_WRITE*XLEN-1:0] wd,
                                        logic [NUM_WRITE-1:0] we,
                                        logic rstN);
        expect_t e;
        e = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            int a;
            a = int'(ra[i*AW +: AW]);
            if (a != 0) begin
                e.data[i*XLEN +: XLEN] = modelMem[a];
                e.pend[i]              = modelPend[a];
            end
`ifdef REGFILE_BYPASS_EN
            if (rstN && a != 0) begin
                for (int k = 0; k < NUM_WRITE; k++) begin
                    if (we[k] && int'(wa[k*AW +: AW]) == a) begin
                        e.data[i*XLEN +: XLEN] = wd[k*XLEN +: XLEN];
                        e.pend[i]              = 1'b0;
                    end
                end
            end
`else
            if (rstN && wa == '0 && wd == '0 && we == '0) e.pend = e.pend;
`endif
        end
        return e;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < NUM_REGS; r++) begin
            modelMem[r]  = '0;
            modelPend[r] = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, queue the expected reads, then retire the edge
    // into the model. Called at posedge+1.
    task automatic applyStimulus(input logic [NUM_READ*AW-1:0] ra,
                                 input logic [NUM_WRITE*AW-1:0] wa,
                                 input logic [NUM_WRITE*XLEN-1:0] wd,
                                 input logic [NUM_WRITE-1:0] we,
                                 input logic iv,
                                 input logic [AW-1:0] ir,
                                 input logic rstN);
        read_register_i   = ra;
        write_register_i  = wa;
        write_back_data_i = wd;
        ctrl_write_back_i = we;
        issue_valid_i     = iv;
        issue_register_i  = ir;
        reset_i           = rstN;
        expQ.push_back(predict(ra, wa, wd, we, rstN));
        @(posedge clk);
        if (!rstN) begin
            modelReset();
        end else begin
            for (int k = 0; k < NUM_WRITE; k++) begin
                int a;
                a = int'(wa[k*AW +: AW]);
                if (we[k] && a != 0) begin
                    modelMem[a]  = wd[k*XLEN +: XLEN];
                    modelPend[a] = 1'b0;
                end
            end
            if (iv && ir != '0) modelPend[int'(ir)] = 1'b1;
        end
        cycleNum++;
        #1;
    endtask

    task automatic readPair(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        applyStimulus({a1, a0}, '0, '0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic checkOutput(input string name, input logic [XLEN-1:0] actual,
                               input logic [XLEN-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cycleNum, actual, expected);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expect_t e;
            e = expQ.pop_front();
            for (int i = 0; i < NUM_READ; i++) begin
                checkOutput($sformatf("data[%0d]", i), register_data_o[i*XLEN +: XLEN],
                            e.data[i*XLEN +: XLEN]);
                checkOutput($sformatf("pending[%0d]", i), {31'b0, pending_o[i]},
                            {31'b0, e.pend[i]});
            end
        end
    end

    initial begin
        logic [NUM_READ*AW-1:0]    ra;
        logic [NUM_WRITE*AW-1:0]   wa;
        logic [NUM_WRITE*XLEN-1:0] wd;
        logic [NUM_WRITE-1:0]      we;
        reg_addr_t                 ir;
        int                        waitCycles;

        reset_i           = 1'b0;
        read_register_i   = '0;
        write_register_i  = '0;
        write_back_data_i = '0;
        ctrl_write_back_i = '0;
        issue_valid_i     = 1'b0;
        issue_register_i  = '0;
        modelReset();
        @(posedge clk);
        #1;

        // Post-reset: every register reads zero and nothing is pending.
        for (int a = 1; a < NUM_REGS; a += 2) begin
            readPair(AW'(a + 1), AW'(a));
        end

        // Dual write to distinct registers, then read both back.
        applyStimulus({5'd2, 5'd1}, {5'd2, 5'd1}, {32'hABCDABCD, 32'hAABBCCDD},
                      2'b11, 1'b0, '0, 1'b1);
        readPair(5'd2, 5'd1);

        // Colliding writes: port 1 wins. Writes to x0 are dropped.
        applyStimulus({5'd5, 5'd5}, {5'd5, 5'd5}, {32'h22222222, 32'h11111111},
                      2'b11, 1'b0, '0, 1'b1);
        readPair(5'd5, 5'd5);
        applyStimulus({5'd0, 5'd0}, {5'd0, 5'd0}, {32'hFFFFFFFF, 32'hFFFFFFFF},
                      2'b11, 1'b1, 5'd0, 1'b1);
        readPair(5'd0, 5'd5);

        // Read while writing x3, then after the edge.
        applyStimulus({5'd3, 5'd3}, {5'd0, 5'd3}, {32'h0, 32'hA0B0C0D0},
                      2'b01, 1'b0, '0, 1'b1);
        readPair(5'd3, 5'd3);

        // Scoreboard: issue, retire, then issue and retire on the same edge.
        applyStimulus({5'd7, 5'd7}, '0, '0, '0, 1'b1, 5'd7, 1'b1);
        readPair(5'd7, 5'd7);
        applyStimulus({5'd7, 5'd7}, {5'd0, 5'd7}, {32'h0, 32'h00000077},
                      2'b01, 1'b0, '0, 1'b1);
        readPair(5'd7, 5'd7);
        applyStimulus({5'd7, 5'd7}, '0, '0, '0, 1'b1, 5'd7, 1'b1);
        applyStimulus({5'd7, 5'd7}, {5'd7, 5'd0}, {32'h00000777, 32'h0},
                      2'b10, 1'b1, 5'd7, 1'b1);
        readPair(5'd7, 5'd7);

        // Reset mid-stream discards data and pending state.
        applyStimulus({5'd9, 5'd9}, '0, '0, '0, 1'b1, 5'd9, 1'b1);
        applyStimulus({5'd9, 5'd9}, {5'd0, 5'd9}, {32'h0, 32'h00001234},
                      2'b01, 1'b1, 5'd9, 1'b1);
        readPair(5'd9, 5'd7);
        applyStimulus({5'd9, 5'd7}, {5'd9, 5'd9}, {32'h5555AAAA, 32'h0F0F0F0F},
                      2'b11, 1'b1, 5'd9, 1'b0);
        readPair(5'd9, 5'd7);

        // Random traffic focused on a small register window for collisions.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_READ; i++) ra[i*AW +: AW] = AW'($urandom_range(0, 7));
            for (int k = 0; k < NUM_WRITE; k++) begin
                wa[k*AW +: AW]     = AW'($urandom_range(0, 7));
                wd[k*XLEN +: XLEN] = $urandom;
            end
            we = NUM_WRITE'($urandom_range(0, 3));
            ir = AW'($urandom_range(0, 7));
            applyStimulus(ra, wa, wd, we, 1'($urandom_range(0, 1)), ir,
                          ($urandom_range(0, 39) != 0));
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 5) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_register_file_mp
